// File: rtl/fb_capture_pkg.sv
// Shared types for the framebuffer stream capture block.
// Bus FSM states and the pixel FIFO entry layout.
package fb_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  typedef struct packed {
    logic        last;
    logic [23:0] addr;
    logic [15:0] data;
  } entry_t;

  localparam logic [3:0] FULL_MASK = 4'hF;
  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; rdata shows the head entry.
// Ports: clk, reset_n_i, flush, push/wdata, pop/rdata, full, empty.
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  // A flush empties the FIFO first, so a push in the
  // same cycle always has room and lands in slot 0.
  assign do_push = push && (flush || !full);
  assign do_pop  = pop && !empty && !flush;
  assign wr_idx  = flush ? '0 : wp;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= do_push ? AW'(1) : '0;
      rp  <= '0;
      cnt <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) begin
        wp <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fb_stream_capture.sv
// Captures a 16-bit pixel stream into the framebuffer via the access bus.
// Ports: clk/reset_n_i, stream in (start/base/valid/data), bus out, status.
module fb_stream_capture
  import fb_capture_pkg::*;
#(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        start_frame_i,
  input  logic [23:0] base_address_i,
  input  logic        valid_i,
  input  logic [15:0] data_i,
  output logic        sel_o,
  output logic        wr_o,
  output logic [3:0]  mask_o,
  output logic [23:0] address_o,
  output logic [15:0] data_out_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        frame_done_o
);

  localparam int PIX_TOTAL = FB_WIDTH * FB_HEIGHT;
  localparam int CW = $clog2(PIX_TOTAL + 1);
  localparam logic [CW-1:0] PIX_MAX  = CW'(PIX_TOTAL);
  localparam logic [CW-1:0] LAST_IDX = CW'(PIX_TOTAL - 1);

  state_t        state;
  logic          armed;
  logic [CW-1:0] count;
  logic [23:0]   next_addr;
  logic          cur_last;

  logic          eff_armed;
  logic [CW-1:0] eff_count;
  logic [23:0]   eff_addr;
  logic          take;
  logic          room;
  logic          drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        wr_entry;
  entry_t        head;

  // start_frame_i takes effect in its own cycle, so a pixel
  // arriving with it becomes index 0 at base_address_i.
  assign eff_armed = armed | start_frame_i;
  assign eff_count = start_frame_i ? '0 : count;
  assign eff_addr  = start_frame_i ? base_address_i : next_addr;

  assign take      = valid_i && eff_armed && (eff_count < PIX_MAX);
  assign room      = start_frame_i || !fifo_full;
  assign fifo_push = take && room;
  assign drop      = take && !room;

  assign wr_entry = '{
    last: (eff_count == LAST_IDX),
    addr: eff_addr,
    data: data_i
  };

  // Never pop on a flush: the head belongs to the old frame.
  assign fifo_pop = (state == IDLE) && !fifo_empty && !start_frame_i;
  assign busy_o   = !fifo_empty || sel_o;

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n_i(reset_n_i),
    .flush    (start_frame_i),
    .push     (fifo_push),
    .wdata    (wr_entry),
    .pop      (fifo_pop),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Dropped in-frame pixels still advance count and address
  // so that later pixels keep their position in the frame.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      armed      <= 1'b0;
      count      <= '0;
      next_addr  <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (start_frame_i) begin
        armed <= 1'b1;
      end
      if (take) begin
        count     <= eff_count + 1'b1;
        next_addr <= eff_addr + 24'd1;
      end else if (start_frame_i) begin
        count     <= '0;
        next_addr <= base_address_i;
      end
      if (start_frame_i) begin
        overflow_o <= 1'b0;
      end else if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      sel_o        <= 1'b0;
      wr_o         <= 1'b0;
      mask_o       <= '0;
      address_o    <= '0;
      data_out_o   <= '0;
      cur_last     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            sel_o      <= 1'b1;
            wr_o       <= 1'b1;
            mask_o     <= FULL_MASK;
            address_o  <= head.addr;
            data_out_o <= head.data;
            cur_last   <= head.last;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ack_i) begin
            sel_o        <= 1'b0;
            wr_o         <= 1'b0;
            mask_o       <= '0;
            frame_done_o <= cur_last;
            state        <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_stream_capture.sv
// Self-checking bench for fb_stream_capture (8x4 frame, 16-deep FIFO).
// Directed scenarios then random traffic against a queue-based model.
module tb_fb_stream_capture;

  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 16;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_frame_i = 1'b0;
  logic [23:0] base_address_i = '0;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ack_i = 1'b0;
  logic        sel_o;
  logic        wr_o;
  logic [3:0]  mask_o;
  logic [23:0] address_o;
  logic [15:0] data_out_o;
  logic        busy_o;
  logic        overflow_o;
  logic        frame_done_o;

  always #5 clk = ~clk;

  fb_stream_capture #(
    .FB_WIDTH(W),
    .FB_HEIGHT(H),
    .FIFO_DEPTH(D)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .start_frame_i (start_frame_i),
    .base_address_i(base_address_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .sel_o         (sel_o),
    .wr_o          (wr_o),
    .mask_o        (mask_o),
    .address_o     (address_o),
    .data_out_o    (data_out_o),
    .ack_i         (ack_i),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .frame_done_o  (frame_done_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFO as a queue of {last, addr, data},
  // bus as a three-phase write (request, gap, idle).
  logic [40:0] mq[$];
  logic [40:0] m_cur = '0;
  int          m_phase = 0;
  bit          m_armed = 0;
  int          m_cnt = 0;
  logic [23:0] m_base = '0;
  bit          m_ovf = 0;
  bit          m_fd = 0;
  bit          m_full;
  bit          m_pop;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mq.delete();
      m_phase = 0;
      m_cur   = '0;
      m_armed = 0;
      m_cnt   = 0;
      m_ovf   = 0;
      m_fd    = 0;
    end else begin
      m_full = !start_frame_i && (mq.size() >= D);
      m_pop  = (m_phase == 0) && (mq.size() > 0) && !start_frame_i;
      m_fd   = 0;
      if (m_phase == 0) begin
        if (m_pop) begin
          m_cur   = mq.pop_front();
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ack_i) begin
          m_fd    = m_cur[40];
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      if (start_frame_i) begin
        mq.delete();
        m_armed = 1;
        m_cnt   = 0;
        m_base  = base_address_i;
        m_ovf   = 0;
      end
      if (valid_i && m_armed && m_cnt < N) begin
        if (m_full) m_ovf = 1;
        else mq.push_back({m_cnt == N - 1, m_base + 24'(m_cnt), data_i});
        m_cnt++;
      end
    end
  end

  logic [39:0] wlog[$];
  int fd_cnt = 0;
  int wcnt = 0;
  int lat = 1;
  bit spur = 0;
  bit rnd_lat = 0;

  task automatic check_outputs();
    chk("sel", sel_o, m_phase == 1);
    if (m_phase == 1) begin
      chk("addr", address_o, m_cur[39:16]);
      chk("data", data_out_o, m_cur[15:0]);
      chk("wr", wr_o, 1);
      chk("mask", mask_o, 4'hF);
    end else begin
      chk("mask_idle", mask_o, 0);
      chk("wr_idle", wr_o, 0);
    end
    chk("frame_done", frame_done_o, m_fd);
    chk("overflow", overflow_o, m_ovf);
    chk("busy", busy_o, (mq.size() > 0) || (m_phase == 1));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_outputs();
    if (frame_done_o) fd_cnt++;
    if (sel_o) begin
      wcnt++;
      if (rnd_lat && wcnt == 1) lat = $urandom_range(0, 4);
      ack_i = (wcnt > lat);
      if (ack_i) wlog.push_back({address_o, data_out_o});
    end else begin
      wcnt  = 0;
      ack_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start_frame_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic pix(input logic [15:0] d);
    valid_i = 1'b1;
    data_i  = d;
    cyc();
  endtask

  task automatic start(input logic [23:0] b);
    start_frame_i  = 1'b1;
    base_address_i = b;
    cyc();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy_o && k < 3000) begin
      cyc();
      k++;
    end
    chk("drain_bound", busy_o, 0);
    repeat (3) cyc();
  endtask

  logic [15:0] t1d[4] = '{16'h0F00, 16'h00F0, 16'h000F, 16'h0FFF};

  initial begin
    // reset state
    repeat (3) cyc();
    chk("rst_sel", sel_o, 0);
    chk("rst_mask", mask_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_addr", address_o, 0);
    reset_n_i = 1'b1;
    cyc();
    // not armed yet: pixels vanish
    repeat (3) pix(16'h0123);
    chk("prestart_busy", busy_o, 0);

    // four pixels, ack one cycle after sel
    lat = 1;
    wlog.delete();
    start(24'h000100);
    for (int i = 0; i < 4; i++) pix(t1d[i]);
    drain();
    chk("t1_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wlog[i][39:16], 24'h100 + 24'(i));
      chk("t1_data", wlog[i][15:0], t1d[i]);
    end

    // slow ack, FIFO overflow
    lat = 20;
    wlog.delete();
    start(24'h000000);
    for (int i = 0; i < 20; i++) pix(16'(i));
    chk("t2_ovf_set", overflow_o, 1);
    drain();
    chk("t2_count", wlog.size(), 17);
    for (int i = 0; i < 17; i++) begin
      chk("t2_addr", wlog[i][39:16], 24'(i));
      chk("t2_data", wlog[i][15:0], 16'(i));
    end
    chk("t2_ovf_hold", overflow_o, 1);
    start(24'h000000);
    chk("t2_ovf_clr", overflow_o, 0);

    // frame end: 34 pixels into a 32-pixel frame
    lat = 0;
    wlog.delete();
    fd_cnt = 0;
    start(24'h000500);
    for (int i = 0; i < 34; i++) begin
      pix(16'(i + 16'h0100));
      cyc();
      cyc();
    end
    drain();
    chk("t3_count", wlog.size(), N);
    chk("t3_last_addr", wlog[N-1][39:16], 24'h500 + 24'(N - 1));
    chk("t3_done", fd_cnt, 1);
    chk("t3_ovf", overflow_o, 0);

    // restart during an in-flight write with 5 queued
    lat = 10;
    wlog.delete();
    start(24'h001000);
    for (int i = 0; i < 6; i++) pix(16'h0100 + 16'(i));
    chk("t4_inflight", sel_o, 1);
    start(24'h200000);
    pix(16'h0ABC);
    drain();
    chk("t4_count", wlog.size(), 2);
    chk("t4_old_addr", wlog[0][39:16], 24'h001000);
    chk("t4_old_data", wlog[0][15:0], 16'h0100);
    chk("t4_new_addr", wlog[1][39:16], 24'h200000);
    chk("t4_new_data", wlog[1][15:0], 16'h0ABC);

    // address wrap at 2^24
    lat = 1;
    wlog.delete();
    start(24'hFFFFFE);
    for (int i = 0; i < 4; i++) pix(16'h0F0F);
    drain();
    chk("t5_count", wlog.size(), 4);
    chk("t5_a0", wlog[0][39:16], 24'hFFFFFE);
    chk("t5_a1", wlog[1][39:16], 24'hFFFFFF);
    chk("t5_a2", wlog[2][39:16], 24'h000000);
    chk("t5_a3", wlog[3][39:16], 24'h000001);

    // async reset in the middle of a request
    lat = 50;
    start(24'h000300);
    pix(16'h0123);
    for (int k = 0; k < 10 && !sel_o; k++) cyc();
    chk("t6_req", sel_o, 1);
    pix(16'h0456);
    pix(16'h0789);
    #2;
    reset_n_i = 1'b0;
    ack_i = 1'b0;
    wcnt = 0;
    #1;
    chk("t6_sel", sel_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_mask", mask_o, 0);
    repeat (2) cyc();
    reset_n_i = 1'b1;
    repeat (3) pix(16'h0333);
    chk("t6_unarmed", busy_o, 0);
    lat = 1;
    wlog.delete();
    start(24'h000040);
    pix(16'h00AA);
    drain();
    chk("t6_count", wlog.size(), 1);
    chk("t6_addr", wlog[0][39:16], 24'h000040);

    // random traffic
    spur = 1;
    rnd_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        start_frame_i = 1'b1;
        base_address_i = ($urandom_range(0, 1) == 1)
                         ? 24'hFFFFF0 + 24'($urandom_range(0, 15))
                         : 24'($urandom);
      end
      if ($urandom_range(0, 99) < 40) begin
        valid_i = 1'b1;
        data_i  = 16'($urandom) & 16'h0FFF;
      end
      cyc();
    end
    spur = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
